// File: rtl/key_event_conditioner.sv
// Key conditioner: 2-flop synchroniser, per-key debounce, press/release pulse generation.
// Optional autorepeat pulses are built only when KEY_AUTOREPEAT_EN is defined.
module key_event_conditioner #(
    parameter int w_key           = 4,
    parameter bit active_low      = 1'b1,
    parameter int debounce_width  = 16,
    parameter int rep_delay_width = 22,
    parameter int rep_rate_width  = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [w_key-1:0] key_sw,
    output logic [w_key-1:0] key_state,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic [w_key-1:0] key_repeat
);

    // The sync chain powers up holding the "released" raw level so that no
    // phantom press is seen straight out of reset.
    localparam logic [w_key-1:0] SYNC_IDLE = active_low ? {w_key{1'b1}} : {w_key{1'b0}};
    localparam logic [debounce_width-1:0] CNT_MAX = {debounce_width{1'b1}};

    if (w_key < 1 || debounce_width < 1 || rep_delay_width < 1 || rep_rate_width < 1) begin : g_bad_params
        $error("key_event_conditioner: all width parameters must be >= 1");
    end

    logic [w_key-1:0]                     sync1_q, sync1_d;
    logic [w_key-1:0]                     sync2_q, sync2_d;
    logic [w_key-1:0]                     sync_norm;
    logic [w_key-1:0][debounce_width-1:0] cnt_q, cnt_d;
    logic [w_key-1:0]                     state_q, state_d;
    logic [w_key-1:0]                     press_q, press_d;
    logic [w_key-1:0]                     release_q, release_d;

    always_comb begin
        sync1_d   = key_sw;
        sync2_d   = sync1_q;
        sync_norm = active_low ? ~sync2_q : sync2_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < w_key; k++) begin
            if (sync_norm[k] == state_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] != CNT_MAX) begin
                cnt_d[k] = cnt_q[k] + debounce_width'(1);
            end else begin
                // Disagreement has persisted for the full period: accept it.
                state_d[k]   = sync_norm[k];
                cnt_d[k]     = '0;
                press_d[k]   = sync_norm[k];
                release_d[k] = ~sync_norm[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            sync1_q   <= SYNC_IDLE;
            sync2_q   <= SYNC_IDLE;
            cnt_q     <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = (rep_delay_width > rep_rate_width) ? rep_delay_width : rep_rate_width;
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'({rep_delay_width{1'b1}});
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'({rep_rate_width{1'b1}});

    logic [w_key-1:0][REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [w_key-1:0]            rep_phase_q, rep_phase_d;
    logic [w_key-1:0]            repeat_q, repeat_d;

    // rep_phase 0 = waiting out the initial delay, 1 = periodic repeat.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        repeat_d    = '0;
        for (int k = 0; k < w_key; k++) begin
            if (!state_d[k] || press_d[k]) begin
                rep_cnt_d[k]   = '0;
                rep_phase_d[k] = 1'b0;
            end else if ((!rep_phase_q[k] && rep_cnt_q[k] == DELAY_LAST) ||
                         ( rep_phase_q[k] && rep_cnt_q[k] == RATE_LAST)) begin
                repeat_d[k]    = 1'b1;
                rep_cnt_d[k]   = '0;
                rep_phase_d[k] = 1'b1;
            end else begin
                rep_cnt_d[k] = rep_cnt_q[k] + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= '0;
            repeat_q    <= '0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            repeat_q    <= repeat_d;
        end
    end

    assign key_repeat = repeat_q;
`else
    assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_event_conditioner.sv
// Directed and random bench for key_event_conditioner (debounce_width=1, active_low=1).
module tb_key_event_conditioner;

    localparam int DW = 1;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_sw;
    logic [3:0] key_state, key_press, key_release, key_repeat;

    int checks = 0;
    int errors = 0;

    key_event_conditioner #(
        .w_key(4), .active_low(1'b1), .debounce_width(DW),
        .rep_delay_width(3), .rep_rate_width(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .key_sw(key_sw),
        .key_state(key_state), .key_press(key_press),
        .key_release(key_release), .key_repeat(key_repeat)
    );

    always #5 clk = ~clk;

    // Reference model of sync + debounce, updated on the same edges as the DUT.
    logic [3:0] m_s1, m_s2, m_state, m_press, m_rel;
    int         m_run [4];

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            m_s1 <= 4'hF; m_s2 <= 4'hF;
            m_state <= 4'h0; m_press <= 4'h0; m_rel <= 4'h0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else begin
            m_s1 <= key_sw;
            m_s2 <= m_s1;
            for (int i = 0; i < 4; i++) begin
                if (~m_s2[i] != m_state[i]) begin
                    if (m_run[i] == (1 << DW) - 1) begin
                        m_state[i] <= ~m_s2[i];
                        m_press[i] <= ~m_s2[i];
                        m_rel[i]   <= m_s2[i];
                        m_run[i]   <= 0;
                    end else begin
                        m_run[i]   <= m_run[i] + 1;
                        m_press[i] <= 1'b0;
                        m_rel[i]   <= 1'b0;
                    end
                end else begin
                    m_run[i]   <= 0;
                    m_press[i] <= 1'b0;
                    m_rel[i]   <= 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] prev_state;

    initial begin
        reset_n = 1'b1;
        key_sw  = 4'hF;
        tick(); tick();
        check("reset_during", {key_state, key_press, key_release, key_repeat}, 16'h0);
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("reset_after", {key_state, key_press, key_release, key_repeat}, 16'h0);

        // Clean press of key 0 (edge E samples the change)
        key_sw = 4'hE;
        tick();
        check("press_E0_state", {12'h0, key_state}, 16'h0);
        tick(); tick();
        check("press_E2", {key_state, key_press}, 8'h00);
        tick();
        check("press_E3_state", {12'h0, key_state}, 16'h1);
        check("press_E3_press", {12'h0, key_press}, 16'h1);
        check("press_E3_release", {12'h0, key_release}, 16'h0);
        check("press_E3_repeat", {12'h0, key_repeat}, 16'h0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) check("press_pulse_width", {12'h0, key_press}, 16'h0);
            check($sformatf("repeat_p%0d", c), {12'h0, key_repeat},
                  {15'h0, AR && (c == 8 || c == 12 || c == 16)});
        end

        // Release of key 0
        key_sw = 4'hF;
        tick(); tick(); tick();
        check("release_R2", {key_state, key_release, key_repeat}, 12'h100);
        tick();
        check("release_R3_state", {12'h0, key_state}, 16'h0);
        check("release_R3_release", {12'h0, key_release}, 16'h1);
        check("release_R3_press", {12'h0, key_press}, 16'h0);
        check("release_R3_repeat", {12'h0, key_repeat}, 16'h0);
        for (int c = 4; c < 10; c++) begin
            tick();
            check($sformatf("after_release_%0d", c), {key_release, key_repeat}, 8'h00);
        end

        // One-cycle glitch on key 2 must be filtered out
        key_sw = 4'hB;
        tick();
        key_sw = 4'hF;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("glitch_%0d", c), {key_state, key_press, key_release}, 12'h0);
        end

        // All keys together
        key_sw = 4'h0;
        tick(); tick(); tick();
        check("multi_E2", {key_state, key_press}, 8'h00);
        tick();
        check("multi_press", {key_state, key_press, key_release}, 12'hFF0);
        tick();
        check("multi_press_end", {key_state, key_press}, 8'hF0);
        key_sw = 4'hF;
        tick(); tick(); tick(); tick();
        check("multi_release", {key_state, key_press, key_release}, 12'h00F);

        // Key held through reset: press comes 2 + 2**DW cycles after release of reset
        key_sw = 4'hE;
        tick(); tick(); tick(); tick(); tick();
        check("held_pre_reset", {12'h0, key_state}, 16'h1);
        reset_n = 1'b1;
        tick(); tick();
        check("held_in_reset", {key_state, key_press, key_release, key_repeat}, 16'h0);
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("held_D3", {key_state, key_press}, 8'h00);
        tick();
        check("held_D4", {key_state, key_press}, 8'h11);
        key_sw = 4'hF;
        for (int c = 0; c < 6; c++) tick();
        check("held_released", {12'h0, key_state}, 16'h0);

        // Random bounce traffic against the model
        prev_state = key_state;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(1, 0) == 1) key_sw = 4'($urandom);
            tick();
            check("rand_state", {12'h0, key_state}, {12'h0, m_state});
            check("rand_press", {12'h0, key_press}, {12'h0, m_press});
            check("rand_release", {12'h0, key_release}, {12'h0, m_rel});
            check("rand_press_and_release", {12'h0, key_press & key_release}, 16'h0);
            check("rand_toggle_pulse", {12'h0, key_state ^ prev_state},
                  {12'h0, key_press | key_release});
            prev_state = key_state;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
